// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {pc, instr} entries with synchronous flush.
// When empty, the head output keeps showing the last entry it presented.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    output logic         valid_o,
    output logic         full_o,
    output fetch_entry_t head_o
);

    localparam int unsigned PtrW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(QUEUE_DEPTH + 1);

    fetch_entry_t    mem_q [QUEUE_DEPTH];
    fetch_entry_t    mem_d [QUEUE_DEPTH];
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    fetch_entry_t    last_q, last_d;
    logic            do_push, do_pop;

    assign valid_o = (count_q != '0);
    assign full_o  = (count_q == CntW'(QUEUE_DEPTH));
    assign head_o  = valid_o ? mem_q[rd_ptr_q] : last_q;

    always_comb begin
        do_pop   = pop_i && valid_o;
        do_push  = push_i && (!full_o || do_pop);
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        last_d   = head_o;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_entry_i;
                wr_ptr_d        = wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '{pc: 32'h0, instr: NOP_INSTR};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            last_q   <= last_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// PC register, fetch/redirect control and fetch queue feeding decode.
// Define FETCH_STATS_EN to build the fetch/stall/redirect counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] curr_pc,
    input  logic [31:0] instr,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4,
    output logic [31:0] fetch_count
);

    logic [31:0]  pc_q, pc_d;
    logic         fetch, pop, q_full;
    fetch_entry_t push_entry, head;
    logic         unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign curr_pc    = pc_q;
    assign pop        = if_valid && if_ready;
    // A full queue can still accept a push when the head leaves this cycle.
    assign fetch      = !redirect_en && (!q_full || pop);
    assign push_entry = '{pc: pc_q, instr: instr};

    always_comb begin
        pc_d = pc_q;
        if (redirect_en) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (fetch) begin
            pc_d = pc_plus4(pc_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_queue #(
        .QUEUE_DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk_i       (clk),
        .reset_i     (reset),
        .flush_i     (redirect_en),
        .push_i      (fetch),
        .push_entry_i(push_entry),
        .pop_i       (pop),
        .valid_o     (if_valid),
        .full_o      (q_full),
        .head_o      (head)
    );

    assign if_instr    = head.instr;
    assign if_pc       = head.pc;
    assign if_pc_plus4 = pc_plus4(head.pc);

`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count_q, fetch_count_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] redirect_count_q, redirect_count_d;

    always_comb begin
        fetch_count_d    = fetch_count_q + (fetch ? 32'd1 : 32'd0);
        stall_cycles_d   = stall_cycles_q
                         + ((!redirect_en && q_full && !pop) ? 32'd1 : 32'd0);
        redirect_count_d = redirect_count_q + (redirect_en ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count_q    <= 32'h0;
            stall_cycles_q   <= 32'h0;
            redirect_count_q <= 32'h0;
        end else begin
            fetch_count_q    <= fetch_count_d;
            stall_cycles_q   <= stall_cycles_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
`else
    assign fetch_count = 32'h0;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and instruction-fetch stage sitting directly upstream of `Instruction_Memory`. Drives `curr_pc` into the memory, captures the returned `instr` word together with its PC into a small fetch queue, and presents fetched instructions to decode with a valid/ready handshake. Handles sequential PC advance, decode back-pressure, and branch/jump redirects with queue flush.

## Interface
- `RESET_PC`, 32'h0040_0000: byte address fetched first after reset (word index 0x0010_0000 in `Instruction_Memory`).
- `QUEUE_DEPTH`, 2: fetch-queue entries; power of two, minimum 2.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `curr_pc`  out  32  byte address to `Instruction_Memory.currPC`.
- `instr`  in  32  word returned by `Instruction_Memory` in the same cycle as `curr_pc`.
- `redirect_en`  in  1  branch/jump taken; restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored (forced to 0).
- `if_valid`  out  1  queue head holds a valid instruction.
- `if_ready`  in  1  decode accepts the head this cycle.
- `if_instr`  out  32  head instruction word.
- `if_pc`  out  32  byte address of `if_instr`.
- `if_pc_plus4`  out  32  `if_pc + 4`, mod 2^32.
- `fetch_count`  out  32  instructions pushed into the queue since reset.

## Operation
- PC register `pc`; `curr_pc = pc` combinationally.
- Fetch condition: `fetch = !redirect_en && (!full || (if_valid && if_ready))`.
- On fetch: push {pc, instr}; `pc <= pc + 4`, wrapping 32'hFFFF_FFFC -> 32'h0; `fetch_count` increments (wraps at 2^32).
- No fetch: `pc` holds, nothing pushed; the memory read is discarded.
- Pop on `if_valid && if_ready`; the head advances.
- Simultaneous push and pop when full: both occur; occupancy unchanged.
- Redirect, highest priority: all queue entries invalidated; `pc <= {redirect_pc[31:2], 2'b00}`; no push. A head handshake in the redirect cycle counts as consumed (decode owns it); everything else is dropped.
- Empty queue: `if_valid = 0`; `if_instr`, `if_pc`, `if_pc_plus4` hold their last value (0 after reset).
- `if_ready` while `if_valid = 0` is ignored.
- Reset: `pc <= RESET_PC`, queue emptied, `if_valid = 0`, `if_instr`/`if_pc` = 0, `if_pc_plus4` = 4, `fetch_count` = 0. Reset mid-stream discards all in-flight entries; reset dominates redirect.

## Timing
- Fetch-to-valid latency: 1 cycle. An instruction read in cycle N is at the head (if the queue was empty) with `if_valid = 1` in cycle N+1.
- First `if_valid` after reset: the second cycle after `reset` deasserts' edge (cycle 0 fetches RESET_PC, valid in cycle 1).
- Redirect asserted in cycle N: `if_valid = 0` in N+1; `curr_pc = target` in N+1; target valid in N+2. Redirect penalty is 2 cycles.
- Steady state with `if_ready` held high: one instruction per cycle, no bubbles.
- `if_ready` low with the queue full: `curr_pc` held stable until a pop occurs.

## Configuration
- `FETCH_STATS_EN` defined: `fetch_count` is a live counter as described, plus internal `stall_cycles` (cycles where fetch was blocked by a full queue) and `redirect_count`, both reset to 0.
- Without `FETCH_STATS_EN`: no counter logic; `fetch_count` is tied to 32'h0.

## Structure
- Shared package `fetch_pkg` contains:
  - `RESET_PC_DEFAULT` = 32'h0040_0000
  - `NOP_INSTR` = 32'h0000_0000
  - `fetch_entry_t` typedef {pc[31:0], instr[31:0]}
- One sub-module, `fetch_queue`: a parameterised `QUEUE_DEPTH` FIFO of `fetch_entry_t` with a synchronous flush input.
- PC logic, fetch/redirect control and statistics stay in `fetch_unit`.

## Test plan
- Reset, then `if_ready = 1` with memory words A0, A1, A2 -> `if_pc` 0x00400000, 0x00400004, 0x00400008 on consecutive cycles from cycle 1; `fetch_count` reaches 3.
- `if_ready = 0` for 5 cycles -> queue fills at 2 entries and `curr_pc` freezes at 0x00400008. Releasing `if_ready` then delivers 0x00400000 first, with no lost or duplicated PCs.
- `redirect_en = 1`, `redirect_pc = 0x00400043` with a full queue -> next cycle `if_valid = 0` and `curr_pc = 0x00400040`; the following cycle `if_pc = 0x00400040`.
- `redirect_en` and `if_valid && if_ready` in the same cycle -> the head is consumed once, the remaining entry is dropped, and the target follows after 2 cycles.
- Redirect to 0xFFFFFFFC, free-run -> `if_pc` sequence 0xFFFFFFFC, 0x00000000, 0x00000004; `if_pc_plus4` for the first entry is 0x0.
- Assert `reset` mid-stream with a redirect pending -> `curr_pc = 0x00400000`, `if_valid = 0`, `fetch_count = 0` after the edge.
